// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Provides the state encoding, opcode/funct constants, the datapath select
// codes, and a decode helper that maps the IR to the state after DECODE.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_M = 4'd2,
    S_MEM_L  = 4'd3,
    S_WB_L   = 4'd4,
    S_MEM_S  = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_EXEC_B = 4'd8,
    S_EXEC_J = 4'd9,
    S_JAL_WB = 4'd10,
    S_EXEC_I = 4'd11,
    S_WB_I   = 4'd12,
    S_DELAY  = 4'd13,
    S_TRAP   = 4'd14,
    S_HALT   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ITYPE = 3'd0;
  localparam logic [2:0] ALU_MEM   = 3'd1;
  localparam logic [2:0] ALU_BR    = 3'd2;
  localparam logic [2:0] ALU_RTYPE = 3'd3;
  localparam logic [2:0] ALU_ADD   = 3'd4;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // State following DECODE; S_TRAP marks an illegal opcode.
  function automatic state_e decode_next(input logic [31:0] ir);
    state_e nxt;
    casez (ir[31:26])
      6'b000000: nxt = (ir[5:0] == FN_JR) ? S_EXEC_J : S_EXEC_R;
      6'b000010: nxt = S_EXEC_J;
      6'b000011: nxt = S_JAL_WB;
      6'b00010?: nxt = S_EXEC_B;
      6'b100011,
      6'b101011: nxt = S_EXEC_M;
      6'b001???: nxt = S_EXEC_I;
      default:   nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_tmo.sv
// Memory timeout counter (module mips_mc_tmo).
// Ports: clk, rst (sync, active-high), clr (zero the count), en (an access
// is outstanding), ready (memory completes this cycle), expired (this cycle
// is the TMO_CYC-th without ready; the access has timed out).
module mips_mc_tmo #(
  parameter int unsigned TMO_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic ready,
  output logic expired
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en && !ready)
      count <= count + 1'b1;
  end

  // Ready in the final cycle still completes the access.
  assign expired = en && !ready && (count == LAST);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit with its own state register.
// Inputs: cclk, rst (sync, active-high), instr (IR), mem_ready.
// Outputs: memory request/strobe/address select, IR/PC write enables,
// PC source, ALU controls, register-file controls, debug state, sticky
// bus_err (memory timeout) and exc (illegal-opcode pulse).
// Build option: define MIPS_MC_CTRL_TRAP_EN to trap illegal opcodes via the
// TRAP state; otherwise they retire as NOPs and exc is tied low.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int unsigned ALUOP_W   = 3,
  parameter int unsigned DELAY_CYC = 1,
  parameter int unsigned TMO_CYC   = 16
) (
  input  logic               cclk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_write_cond,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [3:0]         state,
  output logic               bus_err,
  output logic               exc
);

  localparam logic [2:0] DLY_LOAD  = 3'(DELAY_CYC);
  localparam bit         HAS_DELAY = (DELAY_CYC != 0);

  state_e     st;
  logic [2:0] dly;
  logic       tmo_expired;

`ifdef MIPS_MC_CTRL_TRAP_EN
  logic exc_q;
  assign exc = exc_q;
`else
  assign exc = 1'b0;
`endif

  // Any cycle without an outstanding access, or one that completes, restarts
  // the count, so every entry into a request state begins from zero.
  mips_mc_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk     (cclk),
    .rst     (rst),
    .clr     (!mem_req || mem_ready),
    .en      (mem_req),
    .ready   (mem_ready),
    .expired (tmo_expired)
  );

  always_ff @(posedge cclk) begin
    if (rst) begin
      st      <= S_FETCH;
      dly     <= '0;
      bus_err <= 1'b0;
`ifdef MIPS_MC_CTRL_TRAP_EN
      exc_q   <= 1'b0;
`endif
    end else begin
`ifdef MIPS_MC_CTRL_TRAP_EN
      exc_q <= 1'b0;
`endif
      if (tmo_expired) begin
        st      <= S_HALT;
        bus_err <= 1'b1;
      end else begin
        case (st)
          S_FETCH:  if (mem_ready) st <= S_DECODE;
          S_DECODE: begin
            if (decode_next(instr) == S_TRAP) begin
`ifdef MIPS_MC_CTRL_TRAP_EN
              st    <= S_TRAP;
              exc_q <= 1'b1;
`else
              st <= S_FETCH;
`endif
            end else begin
              st <= decode_next(instr);
            end
          end
          S_EXEC_M: begin
            if (instr[31:26] == OP_SW) st <= S_MEM_S;
            else                       st <= S_MEM_L;
          end
          S_MEM_L:  if (mem_ready) st <= S_WB_L;
          S_MEM_S: begin
            if (mem_ready) begin
              if (HAS_DELAY) st <= S_DELAY;
              else           st <= S_FETCH;
              dly <= DLY_LOAD;
            end
          end
          S_EXEC_B, S_EXEC_J: begin
            if (HAS_DELAY) st <= S_DELAY;
            else           st <= S_FETCH;
            dly <= DLY_LOAD;
          end
          S_DELAY: begin
            if (dly <= 3'd1) st <= S_FETCH;
            else             dly <= dly - 3'd1;
          end
          S_EXEC_R: st <= S_WB_R;
          S_EXEC_I: st <= S_WB_I;
          S_JAL_WB: st <= S_EXEC_J;
          S_HALT:   st <= S_HALT;
          default:  st <= S_FETCH;
        endcase
      end
    end
  end

  assign state = st;

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 2'b00;
    pc_source     = PCS_ALU;
    alu_op        = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    reg_write     = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = M2R_ALUOUT;
    case (st)
      S_FETCH: begin
        mem_req   = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = 2'd1;
        alu_op    = ALUOP_W'(ALU_ADD);
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALUOP_W'(ALU_ADD);
      end
      S_EXEC_M: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALUOP_W'(ALU_MEM);
      end
      S_MEM_L: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_S: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_WB_L: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_RTYPE);
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALUOP_W'(ALU_ITYPE);
      end
      S_WB_I: reg_write = 1'b1;
      S_EXEC_B: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALU_BR);
        pc_source     = PCS_ALUOUT;
        pc_write_cond = {instr[26], ~instr[26]};
      end
      S_JAL_WB: begin
        reg_write  = 1'b1;
        reg_dst    = RD_RA;
        mem_to_reg = M2R_PC;
      end
      S_EXEC_J: begin
        pc_write = 1'b1;
        if (instr[31:26] == OP_RTYPE && instr[5:0] == FN_JR) pc_source = PCS_RS;
        else                                                 pc_source = PCS_JUMP;
      end
      S_TRAP: begin
        pc_write  = 1'b1;
        pc_source = PCS_ALU;
        alu_op    = ALUOP_W'(ALU_ADD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;

  logic        cclk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]  pc_write_cond, pc_source;
  logic [2:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        reg_write;
  logic [1:0]  reg_dst, mem_to_reg;
  logic [3:0]  state;
  logic        bus_err, exc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 cclk = ~cclk;

  mips_mc_ctrl #(.ALUOP_W(3), .DELAY_CYC(1), .TMO_CYC(16)) dut (
    .cclk          (cclk),
    .rst           (rst),
    .instr         (instr),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .state         (state),
    .bus_err       (bus_err),
    .exc           (exc)
  );

  typedef struct {
    logic [31:0] instr;
    logic        rdy;
    logic [23:0] ctl;  // {state,req,we,iord,irw,pcw,pwc,pcs,aop,sa,sb,rw,rd,m2r}
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  function automatic vec_t mk(input logic [31:0] i, input logic r, input logic [3:0] st,
                              input logic mreq, input logic mwe, input logic io,
                              input logic irw, input logic pcw, input logic [1:0] pwc,
                              input logic [1:0] pcs, input logic [2:0] aop, input logic sa,
                              input logic [1:0] sb, input logic rw, input logic [1:0] rd,
                              input logic [1:0] m2r);
    vec_t v;
    v.instr = i;
    v.rdy   = r;
    v.ctl   = {st, mreq, mwe, io, irw, pcw, pwc, pcs, aop, sa, sb, rw, rd, m2r};
    return v;
  endfunction

  function automatic vec_t fetch(input logic [31:0] i, input logic r);
    return mk(i, r, 4'd0, 1, 0, 0, r, r, 2'd0, 2'd0, 3'd4, 0, 2'd1, 0, 2'd0, 2'd0);
  endfunction
  function automatic vec_t dec(input logic [31:0] i);
    return mk(i, 0, 4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd4, 0, 2'd3, 0, 2'd0, 2'd0);
  endfunction
  function automatic vec_t dly(input logic [31:0] i);
    return mk(i, 0, 4'd13, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 2'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  initial begin
    // LW, immediate ready
    vecs.push_back(fetch(I_LW, 1));
    vecs.push_back(dec(I_LW));
    vecs.push_back(mk(I_LW, 0, 4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd1, 1, 2'd2, 0, 2'd0, 2'd0));
    vecs.push_back(mk(I_LW, 1, 4'd3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 2'd0));
    vecs.push_back(mk(I_LW, 0, 4'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd0, 2'd1));
    vecs.push_back(fetch(I_LW, 0));
    // SW with ready low three cycles in MEM_S
    vecs.push_back(fetch(I_SW, 1));
    vecs.push_back(dec(I_SW));
    vecs.push_back(mk(I_SW, 0, 4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd1, 1, 2'd2, 0, 2'd0, 2'd0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(I_SW, (k == 3), 4'd5, 1, 1, 1, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 2'd0));
    vecs.push_back(dly(I_SW));
    // BNE
    vecs.push_back(fetch(I_BNE, 1));
    vecs.push_back(dec(I_BNE));
    vecs.push_back(mk(I_BNE, 0, 4'd8, 0, 0, 0, 0, 0, 2'b10, 2'd1, 3'd2, 1, 2'd0, 0, 2'd0, 2'd0));
    vecs.push_back(dly(I_BNE));
    // JR
    vecs.push_back(fetch(I_JR, 1));
    vecs.push_back(dec(I_JR));
    vecs.push_back(mk(I_JR, 0, 4'd9, 0, 0, 0, 0, 1, 2'd0, 2'd3, 3'd0, 0, 2'd0, 0, 2'd0, 2'd0));
    vecs.push_back(dly(I_JR));
    // JAL
    vecs.push_back(fetch(I_JAL, 1));
    vecs.push_back(dec(I_JAL));
    vecs.push_back(mk(I_JAL, 0, 4'd10, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd2, 2'd2));
    vecs.push_back(mk(I_JAL, 0, 4'd9, 0, 0, 0, 0, 1, 2'd0, 2'd2, 3'd0, 0, 2'd0, 0, 2'd0, 2'd0));
    vecs.push_back(dly(I_JAL));
    // R-type ADD
    vecs.push_back(fetch(I_ADD, 1));
    vecs.push_back(dec(I_ADD));
    vecs.push_back(mk(I_ADD, 0, 4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd3, 1, 2'd0, 0, 2'd0, 2'd0));
    vecs.push_back(mk(I_ADD, 0, 4'd7, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd1, 2'd0));
    // ADDI
    vecs.push_back(fetch(I_ADDI, 1));
    vecs.push_back(dec(I_ADDI));
    vecs.push_back(mk(I_ADDI, 0, 4'd11, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 1, 2'd2, 0, 2'd0, 2'd0));
    vecs.push_back(mk(I_ADDI, 0, 4'd12, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd0, 2'd0));
    // BEQ
    vecs.push_back(fetch(I_BEQ, 1));
    vecs.push_back(dec(I_BEQ));
    vecs.push_back(mk(I_BEQ, 0, 4'd8, 0, 0, 0, 0, 0, 2'b01, 2'd1, 3'd2, 1, 2'd0, 0, 2'd0, 2'd0));
    vecs.push_back(dly(I_BEQ));

    rst = 1'b1;
    instr = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge cclk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_bus_err", 32'(bus_err), 32'd0);
    check("reset_exc", 32'(exc), 32'd0);
    check("reset_fetch_hold", {28'd0, mem_req, ir_write, pc_write, iord}, {28'd0, 4'b1000});
    tick();

    foreach (vecs[i]) begin
      instr = vecs[i].instr;
      mem_ready = vecs[i].rdy;
      @(negedge cclk);
      check($sformatf("vec%0d", i),
            {8'd0, state, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
             alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg},
            {8'd0, vecs[i].ctl});
      check($sformatf("vec%0d_exc", i), 32'(exc), 32'd0);
      tick();
    end

    // Illegal opcode 0x3F
    instr = I_ILL;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("ill_decode", 32'(state), 32'd1);
    tick();
`ifdef MIPS_MC_CTRL_TRAP_EN
    check("trap_state", 32'(state), 32'd14);
    check("trap_exc", 32'(exc), 32'd1);
    check("trap_pcw", {29'd0, pc_write, pc_source}, {29'd0, 3'b100});
    check("trap_aluop", 32'(alu_op), 32'd4);
    tick();
`endif
    check("ill_to_fetch", 32'(state), 32'd0);
    check("ill_exc_low", 32'(exc), 32'd0);

    // Reset in the middle of a load access
    instr = I_LW;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    check("midrst_in_mem_l", {28'd0, state}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_outs", {28'd0, iord, ir_write, pc_write, mem_we}, 32'd0);

    // Timeout in FETCH: 16 cycles without ready
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) @(posedge cclk);
    #1;
    check("tmo_c16_state", 32'(state), 32'd0);
    check("tmo_c16_err", 32'(bus_err), 32'd0);
    tick();
    check("tmo_halt", 32'(state), 32'd15);
    check("tmo_err", 32'(bus_err), 32'd1);
    check("tmo_req_low", 32'(mem_req), 32'd0);
    mem_ready = 1'b1;
    tick();
    tick();
    check("halt_sticky", {31'd0, bus_err} | {28'd0, state} << 1, {27'd0, 4'd15, 1'b1});
    mem_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tmo_rst_state", 32'(state), 32'd0);
    check("tmo_rst_err", 32'(bus_err), 32'd0);

    // Ready arriving on cycle 16 completes the fetch
    repeat (15) @(posedge cclk);
    #1;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("late_ready_state", 32'(state), 32'd1);
    check("late_ready_err", 32'(bus_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
